// File: rtl/branch_target_pipe.sv
// Branch target/taken/next-PC unit for BEQ/BNE/BLT/BGE; optional BRANCH_STATS_EN adds handshake counters.
// Latency: 2 cycles from input handshake to OutValid; throughput 1/cycle.
// Backpressure: OutReady stalls stage 2, stage 1 fills behind it; InReady drops only when both are full.
module branch_target_pipe #(
    parameter int WIDTH        = 32,
    parameter int OFFSET_WIDTH = 16,
    parameter int SHIFT        = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Flush,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [1:0]              BranchOp,
    input  logic [WIDTH-1:0]        PC,
    input  logic [OFFSET_WIDTH-1:0] Offset,
    input  logic [WIDTH-1:0]        ValueIn1,
    input  logic [WIDTH-1:0]        ValueIn2,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    Taken,
    output logic [WIDTH-1:0]        Target,
    output logic [WIDTH-1:0]        NextPC
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]             BranchCount,
    output logic [31:0]             TakenCount
`endif
);

    typedef enum logic [1:0] {
        OP_BEQ = 2'b00,
        OP_BNE = 2'b01,
        OP_BLT = 2'b10,
        OP_BGE = 2'b11
    } br_op_e;

    localparam logic [WIDTH-1:0] FALL_STEP = WIDTH'(1) << SHIFT;

    // Stage 1: raw captured request
    logic                    s1_valid_q, s1_valid_d;
    logic [1:0]              s1_op_q, s1_op_d;
    logic [WIDTH-1:0]        s1_pc_q, s1_pc_d;
    logic [OFFSET_WIDTH-1:0] s1_off_q, s1_off_d;
    logic [WIDTH-1:0]        s1_a_q, s1_a_d;
    logic [WIDTH-1:0]        s1_b_q, s1_b_d;

    // Stage 2: registered results
    logic                    s2_valid_q, s2_valid_d;
    logic                    taken_q, taken_d;
    logic [WIDTH-1:0]        target_q, target_d;
    logic [WIDTH-1:0]        next_pc_q, next_pc_d;

    logic                    s1_advance, s2_advance;
    logic [WIDTH-1:0]        off_sext, br_target, br_fall;
    logic                    br_lt, br_taken;

    always_comb begin
        off_sext  = WIDTH'($signed(s1_off_q));
        br_target = s1_pc_q + (off_sext << SHIFT);
        br_fall   = s1_pc_q + FALL_STEP;
        br_lt     = $signed(s1_a_q) < $signed(s1_b_q);
        br_taken  = 1'b0;
        case (br_op_e'(s1_op_q))
            OP_BEQ:  br_taken = (s1_a_q == s1_b_q);
            OP_BNE:  br_taken = (s1_a_q != s1_b_q);
            OP_BLT:  br_taken = br_lt;
            OP_BGE:  br_taken = !br_lt;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        s2_advance = !s2_valid_q || OutReady;
        s1_advance = !s1_valid_q || s2_advance;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_pc_d    = s1_pc_q;
        s1_off_d   = s1_off_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        taken_d    = taken_q;
        target_d   = target_q;
        next_pc_d  = next_pc_q;

        if (s1_advance) begin
            s1_valid_d = InValid;
            if (InValid) begin
                s1_op_d  = BranchOp;
                s1_pc_d  = PC;
                s1_off_d = Offset;
                s1_a_d   = ValueIn1;
                s1_b_d   = ValueIn2;
            end
        end

        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                taken_d   = br_taken;
                target_d  = br_target;
                next_pc_d = br_taken ? br_target : br_fall;
            end
        end

        // Flush only kills valid bits; stale data is harmless behind OutValid=0
        if (Flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_pc_q    <= '0;
            s1_off_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
            next_pc_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_pc_q    <= s1_pc_d;
            s1_off_q   <= s1_off_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
            next_pc_q  <= next_pc_d;
        end
    end

    assign InReady  = s1_advance;
    assign OutValid = s2_valid_q;
    assign Taken    = taken_q;
    assign Target   = target_q;
    assign NextPC   = next_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic        out_hs;

    // A result presented during Flush is treated as discarded, not delivered
    always_comb begin
        out_hs       = s2_valid_q && OutReady && !Flush;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (out_hs) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (taken_q) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign BranchCount = branch_cnt_q;
    assign TakenCount  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_target_pipe.sv
// Bench for branch_target_pipe: fixed vectors, hand sequences for stall/flush/reset, random traffic vs a queue model.
module tb_branch_target_pipe;
    localparam int W  = 32;
    localparam int OW = 16;

    logic          Clk = 1'b0;
    logic          Reset, Flush, InValid, InReady;
    logic [1:0]    BranchOp;
    logic [W-1:0]  PC, ValueIn1, ValueIn2, Target, NextPC;
    logic [OW-1:0] Offset;
    logic          OutValid, OutReady, Taken;
`ifdef BRANCH_STATS_EN
    logic [31:0]   BranchCount, TakenCount;
`endif

    branch_target_pipe #(.WIDTH(W), .OFFSET_WIDTH(OW), .SHIFT(2)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .BranchOp(BranchOp), .PC(PC), .Offset(Offset), .ValueIn1(ValueIn1), .ValueIn2(ValueIn2),
        .OutValid(OutValid), .OutReady(OutReady), .Taken(Taken), .Target(Target), .NextPC(NextPC)
`ifdef BRANCH_STATS_EN
        , .BranchCount(BranchCount), .TakenCount(TakenCount)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference rules written directly from the arithmetic definition
    function automatic logic ref_taken(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    return sa == sb;
            2'd1:    return sa != sb;
            2'd2:    return sa < sb;
            default: return !(sa < sb);
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] off);
        longint o, p;
        o = $signed(off);
        p = longint'(pc);
        return 32'(p + o * 4);
    endfunction

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] nxt;
        int          acc;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    logic [31:0] m_bc = 0;
    logic [31:0] m_tc = 0;

    task automatic check_outputs();
        logic exp_v;
        exp_v = (q.size() > 0) && ((cyc - q[0].acc) >= 1);
        chk("out_valid", OutValid, exp_v);
        if (exp_v && OutValid) begin
            chk("taken", Taken, q[0].taken);
            chk("target", Target, q[0].tgt);
            chk("next_pc", NextPC, q[0].nxt);
        end
`ifdef BRANCH_STATS_EN
        chk("branch_count", BranchCount, m_bc);
        chk("taken_count", TakenCount, m_tc);
`endif
    endtask

    // One clock: inputs are already driven; check ready, update model at the edge, check outputs at negedge
    task automatic cycle();
        logic acc, ohs, exp_rdy;
        ent_t e;
        #1;
        exp_rdy = (q.size() < 2) || OutReady;
        chk("in_ready", InReady, exp_rdy);
        acc = InValid && InReady;
        ohs = OutValid && OutReady;
        e.taken = ref_taken(BranchOp, ValueIn1, ValueIn2);
        e.tgt   = ref_target(PC, Offset);
        e.nxt   = e.taken ? e.tgt : PC + 32'd4;
        @(posedge Clk);
        cyc++;
        e.acc = cyc;
        if (Reset) begin
            q.delete();
            m_bc = 0;
            m_tc = 0;
        end else if (Flush) begin
            q.delete();
        end else begin
            if (ohs && q.size() > 0) begin
                m_bc++;
                if (q[0].taken) m_tc++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        @(negedge Clk);
        check_outputs();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] pc;
        logic [15:0] off;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl[10];

    task automatic drive_vec(input vec_t v);
        BranchOp = v.op; PC = v.pc; Offset = v.off; ValueIn1 = v.a; ValueIn2 = v.b;
    endtask

    initial begin
        logic [31:0] snap_t, snap_n, snap_bc, snap_tc;
        logic        snap_tk;
        logic        pv, pr, pf, prst, ptk;
        logic [31:0] ptg, pnx;

        tbl[0] = '{2'd0, 32'h100,      16'h0004, 32'd10,       32'd10,       1'b1, 32'h110,      32'h110};
        tbl[1] = '{2'd1, 32'h200,      16'hFFFF, 32'd7,        32'd7,        1'b0, 32'h1FC,      32'h204};
        tbl[2] = '{2'd2, 32'h300,      16'h0008, 32'hFFFFFFFF, 32'd1,        1'b1, 32'h320,      32'h320};
        tbl[3] = '{2'd0, 32'hFFFFFFFC, 16'h0001, 32'd5,        32'd5,        1'b1, 32'h0,        32'h0};
        tbl[4] = '{2'd3, 32'h1000,     16'h8000, 32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFE1000, 32'h1004};
        tbl[5] = '{2'd3, 32'h40,       16'h0002, 32'd5,        32'd5,        1'b1, 32'h48,       32'h48};
        tbl[6] = '{2'd1, 32'h80,       16'h7FFF, 32'd1,        32'd2,        1'b1, 32'h2007C,    32'h2007C};
        tbl[7] = '{2'd2, 32'h10,       16'h0001, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h14,       32'h14};
        tbl[8] = '{2'd2, 32'hFFFFFFF0, 16'h0000, 32'd5,        32'hFFFFFFFB, 1'b0, 32'hFFFFFFF0, 32'hFFFFFFF4};
        tbl[9] = '{2'd1, 32'hFFFFFFFC, 16'h0003, 32'd0,        32'd0,        1'b0, 32'h8,        32'h0};

        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        drive_vec(tbl[0]);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_out_valid", OutValid, 1'b0);
        chk("rst_taken", Taken, 1'b0);
        chk("rst_target", Target, 32'h0);
        chk("rst_next_pc", NextPC, 32'h0);
        chk("rst_in_ready", InReady, 1'b1);

        // Fixed vectors, exact 2-cycle latency
        for (int i = 0; i < 10; i++) begin
            drive_vec(tbl[i]);
            InValid = 1'b1;
            cycle();
            InValid = 1'b0;
            chk("lat_not_early", OutValid, 1'b0);
            cycle();
            chk("vec_valid", OutValid, 1'b1);
            chk("vec_taken", Taken, tbl[i].taken);
            chk("vec_target", Target, tbl[i].tgt);
            chk("vec_next_pc", NextPC, tbl[i].nxt);
            cycle();
        end

        // Backpressure: two accepts fill the pipe, the third waits
        OutReady = 1'b0; InValid = 1'b1;
        drive_vec(tbl[0]); cycle();
        drive_vec(tbl[1]); cycle();
        drive_vec(tbl[2]);
        #1;
        chk("bp_in_ready_low", InReady, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_valid", OutValid, 1'b1);
            chk("bp_hold_target", Target, tbl[0].tgt);
            chk("bp_hold_next", NextPC, tbl[0].nxt);
        end
        OutReady = 1'b1;
        cycle();
        InValid = 1'b0;
        chk("bp_drain1_target", Target, tbl[1].tgt);
        cycle();
        chk("bp_drain2_valid", OutValid, 1'b1);
        chk("bp_drain2_target", Target, tbl[2].tgt);
        cycle();
        chk("bp_empty", OutValid, 1'b0);

        // Flush with two in flight plus a same-cycle handshake
`ifdef BRANCH_STATS_EN
        snap_bc = BranchCount; snap_tc = TakenCount;
`else
        snap_bc = 0; snap_tc = 0;
`endif
        OutReady = 1'b0; InValid = 1'b1;
        drive_vec(tbl[3]); cycle();
        drive_vec(tbl[4]); cycle();
        drive_vec(tbl[5]); OutReady = 1'b1; Flush = 1'b1;
        cycle();
        Flush = 1'b0; InValid = 1'b0;
        chk("flush_out_valid", OutValid, 1'b0);
        for (int k = 0; k < 3; k++) cycle();
        chk("flush_nothing_emerges", OutValid, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("flush_bc_unchanged", BranchCount, snap_bc);
        chk("flush_tc_unchanged", TakenCount, snap_tc);
`endif

        // Reset with the pipe full
        OutReady = 1'b0; InValid = 1'b1;
        drive_vec(tbl[6]); cycle();
        drive_vec(tbl[7]); cycle();
        InValid = 1'b0; Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        #1;
        chk("rstmid_out_valid", OutValid, 1'b0);
        chk("rstmid_target", Target, 32'h0);
        chk("rstmid_next_pc", NextPC, 32'h0);
        chk("rstmid_in_ready", InReady, 1'b1);
`ifdef BRANCH_STATS_EN
        chk("rstmid_bc", BranchCount, 32'h0);
        chk("rstmid_tc", TakenCount, 32'h0);
`endif
        @(negedge Clk);

        // Random traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            InValid  = ($urandom_range(0, 9) < 7);
            OutReady = ($urandom_range(0, 9) < 6);
            Flush    = ($urandom_range(0, 99) < 3);
            Reset    = ($urandom_range(0, 199) == 0);
            BranchOp = 2'($urandom_range(0, 3));
            PC       = $urandom;
            Offset   = 16'($urandom);
            ValueIn1 = $urandom;
            ValueIn2 = ($urandom_range(0, 3) == 0) ? ValueIn1 : $urandom;
            pv = OutValid; pr = OutReady; pf = Flush; prst = Reset;
            ptk = Taken; ptg = Target; pnx = NextPC;
            cycle();
            if (pv && !pr && !pf && !prst) begin
                chk("stall_valid", OutValid, 1'b1);
                chk("stall_taken", Taken, ptk);
                chk("stall_target", Target, ptg);
                chk("stall_next", NextPC, pnx);
            end
        end

        InValid = 1'b0; Flush = 1'b0; Reset = 1'b0; OutReady = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
        chk("drain_complete", 64'(q.size()), 64'd0);

        snap_t = Target; snap_n = NextPC; snap_tk = Taken;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
